// File: rtl/nvme_track_arbiter_pkg.sv
// Shared NVMe definitions for the completion-tracker arbiter: action ID and
// tracker result widths, plus the arbiter FSM state encoding.
package nvme_track_arbiter_pkg;

  // Width of an action ID as carried on command and tracker interfaces.
  localparam int unsigned CMD_ACTION_ID_BITS = 8;

  // Width of the in-order completion state returned by the tracker.
  localparam int unsigned TRACK_INFO_BITS = 2;

  // Arbiter sequencing: pick a requester, pulse the tracker, wait for its result.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nvme_track_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// last_grant+1 (wrapping) whose valid bit is set.
module nvme_track_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [IDX_BITS-1:0] last_grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                any
);

  // Walk the ring starting one past the previous winner; the first hit wins.
  always_comb begin
    int unsigned cand;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_grant) + off) % NUM_REQ;
      if (!any && req_valid[cand[IDX_BITS-1:0]]) begin
        any       = 1'b1;
        grant_idx = cand[IDX_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/nvme_track_arbiter.sv
// Round-robin arbiter sharing the completion-tracker update port among
// NUM_REQ requesters. Exactly one update is in flight at a time; the update ID
// is held until the tracker strobes done and the result is routed back to the
// winner. Optional watchdog enabled by defining NVME_TRACK_ARB_TIMEOUT_EN.
module nvme_track_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ID_BITS         = nvme_track_arbiter_pkg::CMD_ACTION_ID_BITS,
  parameter int unsigned TRACK_INFO_BITS = nvme_track_arbiter_pkg::TRACK_INFO_BITS,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ID_BITS-1:0]   req_id,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [TRACK_INFO_BITS-1:0]   rsp_data,
  input  logic                         track_init,
  output logic                         track_update,
  output logic [ID_BITS-1:0]           track_update_id,
  input  logic                         track_update_done,
  input  logic [TRACK_INFO_BITS-1:0]   track_update_data,
  output logic                         arb_busy,
  output logic                         arb_timeout,
  input  logic                         arb_timeout_clear
);

  import nvme_track_arbiter_pkg::*;

  localparam int unsigned IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q;
  logic [IDX_BITS-1:0] grant_idx_q;
  logic [IDX_BITS-1:0] last_grant_q;
  logic [IDX_BITS-1:0] pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                timeout_hit;

  nvme_track_arbiter_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  assign pick_onehot  = NUM_REQ'(1) << pick_idx;
  assign grant_onehot = NUM_REQ'(1) << grant_idx_q;

`ifdef NVME_TRACK_ARB_TIMEOUT_EN
  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_BITS-1:0] wait_cnt_q;

  // Done arriving on the final watchdog cycle still counts as a normal completion.
  assign timeout_hit = (state_q == StWait) && !track_update_done &&
                       (wait_cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in WAIT; restart while the update pulse is issued.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wait_cnt_q <= '0;
    end else if (state_q == StIssue) begin
      wait_cnt_q <= '0;
    end else if (state_q == StWait) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky watchdog flag; a new expiry beats a simultaneous clear.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      arb_timeout <= 1'b0;
    end else if (timeout_hit) begin
      arb_timeout <= 1'b1;
    end else if (arb_timeout_clear) begin
      arb_timeout <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign arb_timeout    = 1'b0;
  assign unused_timeout = arb_timeout_clear ^ (TIMEOUT_CYCLES == 0);
`endif

  // Arbitration FSM; every output is registered so the tracker sees clean pulses.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q         <= StIdle;
      grant_idx_q     <= '0;
      last_grant_q    <= IDX_BITS'(NUM_REQ - 1);
      req_ready       <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      track_update    <= 1'b0;
      track_update_id <= '0;
      arb_busy        <= 1'b0;
    end else begin
      req_ready    <= '0;
      rsp_valid    <= '0;
      track_update <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // track_init low only holds off new grants.
          if (track_init && pick_any) begin
            grant_idx_q     <= pick_idx;
            track_update_id <= req_id[pick_idx*ID_BITS +: ID_BITS];
            req_ready       <= pick_onehot;
            track_update    <= 1'b1;
            arb_busy        <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (track_update_done || timeout_hit) begin
            rsp_valid    <= grant_onehot;
            rsp_data     <= track_update_done ? track_update_data : '0;
            last_grant_q <= grant_idx_q;
            arb_busy     <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q  <= StIdle;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
